// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master controller.
package apb_pkg;

  localparam int ADDR_W_DEF      = 12;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef enum logic [1:0] {
    OK      = 2'b00,
    SLVERR  = 2'b01,
    TIMEOUT = 2'b10
  } apb_err_e;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter; o_expired flags the TIMEOUT_CYC-th cycle without pready.
// TIMEOUT_CYC = 0 removes the counter and never expires.
module apb_wait_timer #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic w_unused;
      assign w_unused  = &{1'b0, clk, rst, i_clr, i_en};
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

      logic [CNT_W-1:0] r_cnt;

      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en)  r_cnt <= r_cnt + 1'b1;
      end

      // Fires in the waiting cycle that brings the count to TIMEOUT_CYC.
      assign o_expired = i_en && (r_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB master: request/response port in, APB3 bus out, with
// wait states, PSLVERR reporting and timeout. Define APB_MASTER_APB4_EN for pstrb/pprot.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_write_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_strb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic [1:0]          rsp_err_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic [DATA_W-1:0]   pwdata_o,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pready_i,
  input  logic                pslverr_i
`ifdef APB_MASTER_APB4_EN
  ,
  output logic [DATA_W/8-1:0] pstrb_o,
  output logic [2:0]          pprot_o
`endif
);

  apb_state_e          r_state, w_next;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  apb_err_e            r_err;
  logic                w_expired, w_accept;

  apb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == SETUP),
    .i_en      ((r_state == ACCESS) && !pready_i),
    .o_expired (w_expired)
  );

  // Reset gates req_ready so every output reads 0 while rst is high.
  assign w_accept = req_valid_i && req_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next      = r_state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready_o = !rst;
        if (req_valid_i) w_next = SETUP;
      end
      SETUP: begin
        psel_o = 1'b1;
        w_next = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i || w_expired) w_next = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, because bus and response outputs must read 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= OK;
    end else begin
      if (w_accept) begin
        r_write <= req_write_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
      end
      if (r_state == ACCESS) begin
        if (pready_i) begin
          r_err   <= pslverr_i ? SLVERR : OK;
          r_rdata <= (!r_write && !pslverr_i) ? prdata_i : '0;
        end else if (w_expired) begin
          r_err   <= TIMEOUT;
          r_rdata <= '0;
        end
      end
    end
  end

  assign pwrite_o    = r_write;
  assign paddr_o     = r_addr;
  assign pwdata_o    = r_wdata;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

`ifdef APB_MASTER_APB4_EN
  logic [DATA_W/8-1:0] r_strb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_strb <= '0;
    else if (w_accept) r_strb <= req_write_i ? req_strb_i : '0;
  end

  assign pstrb_o = r_strb;
  assign pprot_o = 3'b000;
`else
  logic w_unused_strb;
  assign w_unused_strb = ^req_strb_i;
`endif

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: directed vector table, reset/stall
// sequences and randomized transfers against a transaction-level model.
module tb_apb_master_ctrl;

  localparam int TO = 8;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
`ifdef APB_MASTER_APB4_EN
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
`endif

  int n_checks = 0;
  int n_errors = 0;

  apb_master_ctrl #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready),
    .pslverr_i(pslverr)
`ifdef APB_MASTER_APB4_EN
    , .pstrb_o(pstrb), .pprot_o(pprot)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic        w;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wait_n;
    logic        slverr;
    logic [31:0] rdata;
    int          stall;
    logic [1:0]  exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Transfer-level reference: how many ACCESS cycles, and what the response must carry.
  function automatic void model(input logic w, input int wait_n, input logic slverr,
                                input logic [31:0] rd, output int n_acc,
                                output logic [1:0] err, output logic [31:0] rdata);
    if (TO > 0 && wait_n >= TO) begin
      n_acc = TO;
      err   = 2'b10;
      rdata = 32'h0;
    end else begin
      n_acc = wait_n + 1;
      err   = slverr ? 2'b01 : 2'b00;
      rdata = (w || slverr) ? 32'h0 : rd;
    end
  endfunction

  task automatic do_xfer(input vec_t v);
    int          n_acc;
    logic [1:0]  m_err;
    logic [31:0] m_rdata;
    logic        last;
    model(v.w, v.wait_n, v.slverr, v.rdata, n_acc, m_err, m_rdata);

    check("idle_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_write = v.w;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_strb  = v.strb;
    tick();
    req_valid = 1'b0;
    req_write = $urandom;
    req_addr  = 12'($urandom);
    req_wdata = $urandom;
    req_strb  = 4'($urandom);

    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_paddr", paddr, v.addr);
    check("setup_pwrite", pwrite, v.w);
    check("setup_pwdata", pwdata, v.wdata);
    check("setup_req_ready", req_ready, 0);
`ifdef APB_MASTER_APB4_EN
    check("setup_pstrb", pstrb, v.w ? v.strb : 4'h0);
    check("pprot", pprot, 0);
`endif

    for (int i = 0; i < n_acc; i++) begin
      tick();
      check("access_psel", psel, 1);
      check("access_penable", penable, 1);
      check("access_paddr", paddr, v.addr);
      check("access_pwdata", pwdata, v.wdata);
      check("access_rsp_valid", rsp_valid, 0);
`ifdef APB_MASTER_APB4_EN
      check("access_pstrb", pstrb, v.w ? v.strb : 4'h0);
`endif
      last    = (i == n_acc - 1) && (m_err != 2'b10);
      pready  = last;
      pslverr = last ? v.slverr : 1'($urandom);
      prdata  = last ? v.rdata : $urandom;
    end
    tick();
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = $urandom;

    for (int s = 0; s <= v.stall; s++) begin
      check("resp_valid", rsp_valid, 1);
      check("resp_rdata", rsp_rdata, v.exp_rdata);
      check("resp_err", rsp_err, v.exp_err);
      check("resp_psel", psel, 0);
      check("resp_penable", penable, 0);
      check("resp_req_ready", req_ready, 0);
      rsp_ready = (s == v.stall);
      tick();
    end
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_psel", psel, 0);
  endtask

  initial begin
    vec_t v;
    int          n_acc;
    logic [1:0]  m_err;
    logic [31:0] m_rdata;

    //                w     addr     wdata         strb  wait slv   rdata         stall err    exp_rdata
    vecs[0] = '{1'b1, 12'h0A4, 32'hDEADBEEF, 4'hF, 0,   1'b0, 32'h0,        0,   2'b00, 32'h0};
    vecs[1] = '{1'b0, 12'h010, 32'h0,        4'h0, 5,   1'b0, 32'h12345678, 0,   2'b00, 32'h12345678};
    vecs[2] = '{1'b1, 12'h3FC, 32'hCAFEF00D, 4'h5, 0,   1'b1, 32'h0,        0,   2'b01, 32'h0};
    vecs[3] = '{1'b0, 12'h020, 32'h0,        4'h0, 2,   1'b1, 32'hFFFF0000, 1,   2'b01, 32'h0};
    vecs[4] = '{1'b0, 12'h100, 32'h0,        4'h0, 100, 1'b0, 32'h0,        0,   2'b10, 32'h0};
    vecs[5] = '{1'b0, 12'h104, 32'h0,        4'h0, 0,   1'b0, 32'hA5A5A5A5, 10,  2'b00, 32'hA5A5A5A5};
    vecs[6] = '{1'b0, 12'hFFF, 32'h0,        4'h0, TO-1, 1'b0, 32'h0BADF00D, 0,  2'b00, 32'h0BADF00D};
    vecs[7] = '{1'b1, 12'h000, 32'h11223344, 4'hC, TO,  1'b1, 32'h0,        2,   2'b10, 32'h0};

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_paddr", paddr, 0);
    check("rst_rsp_err", rsp_err, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) do_xfer(vecs[k]);

    // Reset asserted mid-ACCESS: outputs drop at once, transfer is lost.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h055;
    tick();
    req_valid = 1'b0;
    tick();
    check("rstmid_pre_penable", penable, 1);
    rst = 1'b1;
    #1;
    check("rstmid_psel", psel, 0);
    check("rstmid_penable", penable, 0);
    check("rstmid_paddr", paddr, 0);
    check("rstmid_pwdata", pwdata, 0);
    check("rstmid_pwrite", pwrite, 0);
    check("rstmid_req_ready", req_ready, 0);
    check("rstmid_rsp_valid", rsp_valid, 0);
    check("rstmid_rsp_rdata", rsp_rdata, 0);
    check("rstmid_rsp_err", rsp_err, 0);
`ifdef APB_MASTER_APB4_EN
    check("rstmid_pstrb", pstrb, 0);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rstrel_req_ready", req_ready, 1);
    check("rstrel_psel", psel, 0);
    check("rstrel_rsp_valid", rsp_valid, 0);
    do_xfer(vecs[1]);

    // Randomized transfers checked against the transaction model.
    for (int k = 0; k < 40; k++) begin
      v.w      = 1'($urandom);
      v.addr   = 12'($urandom);
      v.wdata  = $urandom;
      v.strb   = 4'($urandom);
      v.wait_n = $urandom_range(0, TO + 2);
      v.slverr = ($urandom_range(0, 3) == 0);
      v.rdata  = $urandom;
      v.stall  = $urandom_range(0, 3);
      model(v.w, v.wait_n, v.slverr, v.rdata, n_acc, m_err, m_rdata);
      v.exp_err   = m_err;
      v.exp_rdata = m_rdata;
      do_xfer(v);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
